// File: rtl/edge_counter_channel.sv
// -----------------------------------------------------------------------------
// edge_counter_channel
//
// Single-channel pulse-timing capture engine. The external signal is
// synchronised, and its rising and falling edges are detected. Three
// consecutive phases are then measured in clk cycles: active, inactive,
// active. "Active" means high, or low when inversion is selected.
//
// Ports:
//   clk              system clock, all logic on its rising edge
//   rst_sync         asynchronous active-high reset
//   sig_in           asynchronous external signal to measure
//   cfg_enable       1 = arm and capture, 0 = stop and return to IDLE
//   cfg_in_inv       1 = measure the inverted signal (sampled when arming)
//   cfg_trig_enable  1 = trig_out reports capture completion
//   cfg_trig_out     manual trigger level when cfg_trig_enable = 0
//   d1_count         cycles in the first active phase
//   d2_count         cycles in the following inactive phase
//   d3_count         cycles in the second active phase
//   busy             high in ARM, D1, D2, D3
//   done             high in DONE
//   trig_out         registered trigger output
// -----------------------------------------------------------------------------
module edge_counter_channel #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             sig_in,
  input  logic             cfg_enable,
  input  logic             cfg_in_inv,
  input  logic             cfg_trig_enable,
  input  logic             cfg_trig_out,
  output logic [WIDTH-1:0] d1_count,
  output logic [WIDTH-1:0] d2_count,
  output logic [WIDTH-1:0] d3_count,
  output logic             busy,
  output logic             done,
  output logic             trig_out
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_D1,
    S_D2,
    S_D3,
    S_DONE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_s_d;
  logic                   r_inv_q;
  logic [WIDTH-1:0]       r_d1;
  logic [WIDTH-1:0]       r_d2;
  logic [WIDTH-1:0]       r_d3;
  logic                   r_trig;

  logic                   w_s;
  logic                   w_rise_raw;
  logic                   w_fall_raw;
  logic                   w_rise;
  logic                   w_fall;
  logic                   w_abort;
  logic                   w_arm;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] x);
    if (&x) begin
      return x;
    end
    return x + 1'b1;
  endfunction

  // Input synchroniser plus one-cycle history for edge detection.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_sync <= '0;
      r_s_d  <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_s_d  <= w_s;
    end
  end

  assign w_s        = r_sync[SYNC_STAGES-1];
  assign w_rise_raw = w_s & ~r_s_d;
  assign w_fall_raw = ~w_s & r_s_d;

  // Edges are taken from the raw synchronised signal. Inversion only swaps
  // which edge counts as "rise", so it can never manufacture an edge.
  assign w_rise = r_inv_q ? w_fall_raw : w_rise_raw;
  assign w_fall = r_inv_q ? w_rise_raw : w_fall_raw;

  // Dropping the enable overrides every other transition outside IDLE.
  assign w_abort = (r_state != S_IDLE) && !cfg_enable;
  assign w_arm   = (r_state == S_IDLE) && cfg_enable;

  // Inversion is frozen for the whole capture once armed.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_inv_q <= 1'b0;
    end else if (w_arm) begin
      r_inv_q <= cfg_in_inv;
    end
  end

  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    if (w_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (cfg_enable) w_next = S_ARM;
        S_ARM:   if (w_rise)     w_next = S_D1;
        S_D1:    if (w_fall)     w_next = S_D2;
        S_D2:    if (w_rise)     w_next = S_D3;
        S_D3:    if (w_fall)     w_next = S_DONE;
        S_DONE:  w_next = S_DONE;
        default: w_next = S_IDLE;
      endcase
    end
  end

  // Each phase starts at 1 on its opening edge, so an N-cycle phase reads N.
  // Counts are held on abort and in IDLE so partial results stay readable.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_d1 <= '0;
      r_d2 <= '0;
      r_d3 <= '0;
    end else if (!w_abort) begin
      case (r_state)
        S_IDLE: begin
          if (cfg_enable) begin
            r_d1 <= '0;
            r_d2 <= '0;
            r_d3 <= '0;
          end
        end
        S_ARM: begin
          if (w_rise) r_d1 <= WIDTH'(1);
        end
        S_D1: begin
          if (w_fall) r_d2 <= WIDTH'(1);
          else        r_d1 <= sat_inc(r_d1);
        end
        S_D2: begin
          if (w_rise) r_d3 <= WIDTH'(1);
          else        r_d2 <= sat_inc(r_d2);
        end
        S_D3: begin
          if (!w_fall) r_d3 <= sat_inc(r_d3);
        end
        default: ;
      endcase
    end
  end

  // Looking at the next state lets trig_out rise on the same edge that
  // enters DONE.
  always_ff @(posedge clk or posedge rst_sync) begin
    if (rst_sync) begin
      r_trig <= 1'b0;
    end else begin
      r_trig <= cfg_trig_enable ? (w_next == S_DONE) : cfg_trig_out;
    end
  end

  assign d1_count = r_d1;
  assign d2_count = r_d2;
  assign d3_count = r_d3;
  assign busy     = (r_state == S_ARM) || (r_state == S_D1) ||
                    (r_state == S_D2)  || (r_state == S_D3);
  assign done     = (r_state == S_DONE);
  assign trig_out = r_trig;

endmodule

// File: tb/tb_edge_counter_channel.sv
// -----------------------------------------------------------------------------
// tb_edge_counter_channel
//
// Drives pulse trains as lists of phase durations. Because the synchroniser
// delays both edges of a phase equally, the expected count for each phase is
// its duration in cycles, clipped at all-ones.
// -----------------------------------------------------------------------------
module tb_edge_counter_channel;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        sig;
  logic        en;
  logic        inv;
  logic        ten;
  logic        tout;
  logic [31:0] d1;
  logic [31:0] d2;
  logic [31:0] d3;
  logic        busy;
  logic        done;
  logic        trig;

  logic        rst4;
  logic        sig4;
  logic        en4;
  logic [3:0]  e1;
  logic [3:0]  e2;
  logic [3:0]  e3;
  logic        busy4;
  logic        done4;
  logic        trig4;

  int total = 0;
  int bad   = 0;

  edge_counter_channel #(.WIDTH(32), .SYNC_STAGES(2)) dut (
    .clk             (clk),
    .rst_sync        (rst),
    .sig_in          (sig),
    .cfg_enable      (en),
    .cfg_in_inv      (inv),
    .cfg_trig_enable (ten),
    .cfg_trig_out    (tout),
    .d1_count        (d1),
    .d2_count        (d2),
    .d3_count        (d3),
    .busy            (busy),
    .done            (done),
    .trig_out        (trig)
  );

  edge_counter_channel #(.WIDTH(4), .SYNC_STAGES(2)) dut4 (
    .clk             (clk),
    .rst_sync        (rst4),
    .sig_in          (sig4),
    .cfg_enable      (en4),
    .cfg_in_inv      (1'b0),
    .cfg_trig_enable (1'b0),
    .cfg_trig_out    (1'b1),
    .d1_count        (e1),
    .d2_count        (e2),
    .d3_count        (e3),
    .busy            (busy4),
    .done            (done4),
    .trig_out        (trig4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference: a completed capture reports each phase length, saturated.
  function automatic logic [31:0] phase_len(input int n, input int w);
    longint lim;
    lim = (longint'(1) << w) - 1;
    return (n > lim) ? 32'(lim) : 32'(n);
  endfunction

  // One full capture: optional active level before arming (must be ignored),
  // then active n1, inactive n2, active n3, back to inactive.
  task automatic run_capture(input string tag, input logic iv, input int n1,
                             input int n2, input int n3, input logic pre);
    logic idle_lvl;
    logic trig_exp_mid;
    logic trig_exp_end;
    idle_lvl     = iv;
    trig_exp_mid = ten ? 1'b0 : tout;
    trig_exp_end = ten ? 1'b1 : tout;
    en  = 1'b0;
    sig = idle_lvl;
    cyc(4);
    if (pre) begin
      sig = ~idle_lvl;
      cyc(4);
    end
    inv = iv;
    en  = 1'b1;
    cyc(3);
    if (pre) begin
      sig = idle_lvl;
      cyc(3);
    end
    sig = ~idle_lvl;
    cyc(n1);
    sig = idle_lvl;
    check($sformatf("%s.busy_mid", tag), 32'(busy), 32'd1);
    check($sformatf("%s.trig_mid", tag), 32'(trig), 32'(trig_exp_mid));
    cyc(n2);
    sig = ~idle_lvl;
    cyc(n3);
    sig = idle_lvl;
    for (int i = 0; i < 20 && done !== 1'b1; i++) cyc(1);
    check($sformatf("%s.done", tag), 32'(done), 32'd1);
    check($sformatf("%s.busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s.d1", tag), d1, phase_len(n1, 32));
    check($sformatf("%s.d2", tag), d2, phase_len(n2, 32));
    check($sformatf("%s.d3", tag), d3, phase_len(n3, 32));
    check($sformatf("%s.trig_end", tag), 32'(trig), 32'(trig_exp_end));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst  = 1'b1;
    sig  = 1'b0;
    en   = 1'b0;
    inv  = 1'b0;
    ten  = 1'b0;
    tout = 1'b0;
    rst4 = 1'b1;
    sig4 = 1'b0;
    en4  = 1'b0;
    cyc(2);
    check("rst.d1", d1, 32'd0);
    check("rst.d2", d2, 32'd0);
    check("rst.d3", d3, 32'd0);
    check("rst.busy", 32'(busy), 32'd0);
    check("rst.done", 32'(done), 32'd0);
    check("rst.trig", 32'(trig), 32'd0);
    rst  = 1'b0;
    rst4 = 1'b0;

    // Toggling the input while disabled must not touch the counts.
    sig = 1'b1;
    cyc(5);
    sig = 1'b0;
    cyc(5);
    check("idle_toggle.d1", d1, 32'd0);
    check("idle_toggle.busy", 32'(busy), 32'd0);

    run_capture("basic", 1'b0, 10, 20, 5, 1'b0);
    run_capture("inv", 1'b1, 7, 3, 4, 1'b0);

    ten = 1'b1;
    run_capture("trig", 1'b0, 6, 5, 4, 1'b0);
    en = 1'b0;
    cyc(1);
    check("trig_off.trig", 32'(trig), 32'd0);
    check("trig_off.done", 32'(done), 32'd0);
    ten  = 1'b0;
    tout = 1'b1;
    cyc(1);
    check("manual_hi.trig", 32'(trig), 32'd1);
    tout = 1'b0;
    cyc(1);
    check("manual_lo.trig", 32'(trig), 32'd0);

    // Disable four cycles into the inactive phase after a 6-cycle high.
    inv = 1'b0;
    sig = 1'b0;
    cyc(4);
    en = 1'b1;
    cyc(3);
    sig = 1'b1;
    cyc(6);
    sig = 1'b0;
    cyc(6);
    en = 1'b0;
    cyc(1);
    check("abort.busy", 32'(busy), 32'd0);
    check("abort.done", 32'(done), 32'd0);
    check("abort.d1", d1, 32'd6);
    check("abort.d2", d2, 32'd4);
    en = 1'b1;
    cyc(1);
    check("rearm.busy", 32'(busy), 32'd1);
    check("rearm.d1", d1, 32'd0);
    check("rearm.d2", d2, 32'd0);

    for (int k = 0; k < 8; k++) begin
      logic r_inv;
      logic r_pre;
      int   n1;
      int   n2;
      int   n3;
      r_inv = 1'($urandom_range(1, 0));
      r_pre = 1'($urandom_range(1, 0));
      ten   = 1'($urandom_range(1, 0));
      tout  = 1'($urandom_range(1, 0));
      n1    = int'($urandom_range(40, 1));
      n2    = int'($urandom_range(40, 1));
      n3    = int'($urandom_range(40, 1));
      run_capture($sformatf("rnd%0d", k), r_inv, n1, n2, n3, r_pre);
    end
    en = 1'b0;
    cyc(2);

    // Narrow counter: a 20-cycle high phase must clip at 15, then an
    // asynchronous reset mid-capture clears everything before any edge.
    en4 = 1'b1;
    cyc(3);
    sig4 = 1'b1;
    cyc(20);
    sig4 = 1'b0;
    check("sat.d1", 32'(e1), phase_len(20, 4));
    check("sat.busy", 32'(busy4), 32'd1);
    check("sat.trig_manual", 32'(trig4), 32'd1);
    #1;
    rst4 = 1'b1;
    #1;
    check("arst.d1", 32'(e1), 32'd0);
    check("arst.d2", 32'(e2), 32'd0);
    check("arst.d3", 32'(e3), 32'd0);
    check("arst.busy", 32'(busy4), 32'd0);
    check("arst.done", 32'(done4), 32'd0);
    check("arst.trig", 32'(trig4), 32'd0);
    cyc(1);
    rst4 = 1'b0;
    en4  = 1'b0;
    cyc(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
